// File: rtl/decimal_to_other_system_seq.sv
// Converts an unsigned binary value to a right-justified ASCII digit string in base 2..16.
// Each digit is produced by a W-cycle bit-serial restoring divide followed by one emit cycle.
module decimal_to_other_system_seq #(
  parameter int W      = 32,
  parameter int DIGITS = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [W-1:0]          value,
  input  logic [4:0]            base,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [8*DIGITS-1:0]   num_str
);

  localparam int CW = $clog2(W);
  localparam int KW = $clog2(DIGITS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DIV,
    S_EMIT,
    S_DONE,
    S_ERR
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [W-1:0]          quot;
  logic [4:0]            rem;
  logic [4:0]            base_r;
  logic [CW-1:0]         cnt;
  logic [KW-1:0]         k;
  logic [8*DIGITS-1:0]   work;
  logic [4:0]            trial;
  logic                  ge;
  logic [7:0]            ascii;
  logic                  accept;
  logic                  legal;
  logic                  last_slot;

  // done is high in the cycle after DONE/ERR, so a start seen then must be dropped
  assign accept    = start && !done;
  assign legal     = (base >= 5'd2) && (base <= 5'd16);
  assign trial     = {rem[3:0], quot[W-1]};
  assign ge        = (trial >= base_r);
  assign ascii     = (rem < 5'd10) ? (8'h30 + {3'b000, rem}) : (8'h37 + {3'b000, rem});
  assign last_slot = ((k + KW'(1)) == KW'(DIGITS));
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_next = legal ? S_DIV : S_ERR;
        end
      end
      S_DIV: begin
        if (cnt == CW'(W - 1)) begin
          state_next = S_EMIT;
        end
      end
      S_EMIT: begin
        if (quot == '0) begin
          state_next = S_DONE;
        end else if (last_slot) begin
          state_next = S_ERR;
        end else begin
          state_next = S_DIV;
        end
      end
      S_DONE:  state_next = S_IDLE;
      S_ERR:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath: quot doubles as dividend shift register and quotient accumulator
  always_ff @(posedge clk) begin
    if (rst) begin
      quot    <= '0;
      rem     <= '0;
      base_r  <= '0;
      cnt     <= '0;
      k       <= '0;
      work    <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
      num_str <= '0;
    end else begin
      done <= (state == S_DONE) || (state == S_ERR);
      case (state)
        S_IDLE: begin
          if (accept && legal) begin
            quot   <= value;
            base_r <= base;
            rem    <= '0;
            cnt    <= '0;
            k      <= '0;
            work   <= '0;
          end
        end
        S_DIV: begin
          quot <= {quot[W-2:0], ge};
          rem  <= ge ? (trial - base_r) : trial;
          cnt  <= cnt + CW'(1);
        end
        S_EMIT: begin
          for (int i = 0; i < DIGITS; i++) begin
            if (k == KW'(i)) begin
              work[8*i +: 8] <= ascii;
            end
          end
          k   <= k + KW'(1);
          rem <= '0;
          cnt <= '0;
        end
        S_DONE: begin
          num_str <= work;
          err     <= 1'b0;
        end
        S_ERR: begin
          num_str <= '0;
          err     <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decimal_to_other_system_seq.sv
// Directed table-driven bench for decimal_to_other_system_seq (W=32, DIGITS=16),
// plus hand sequences for reset mid-divide, start-while-busy and error hold.
module tb_decimal_to_other_system_seq;

  logic         clk;
  logic         rst;
  logic         start;
  logic [31:0]  value;
  logic [4:0]   base;
  logic         busy;
  logic         done;
  logic         err;
  logic [127:0] num_str;

  int passed;
  int total;

  typedef struct {
    logic [31:0]  value;
    logic [4:0]   base;
    logic [127:0] str;
    logic         err;
    int           lat;
  } vec_t;

  vec_t vecs[11];

  decimal_to_other_system_seq #(.W(32), .DIGITS(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .value   (value),
    .base    (base),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .num_str (num_str)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got === exp) begin
      passed++;
    end else begin
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Pulses start for one cycle and counts edges after the start edge until done
  task automatic apply_stimulus(input logic [31:0] v, input logic [4:0] b, output int lat);
    value = v;
    base  = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check_output("busy_after_start", {127'd0, busy}, 128'd1);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!done && lat < 2000);
  endtask

  task automatic check_result(input string tag, input logic [127:0] exp_str, input logic exp_err,
                              input int exp_lat, input int lat);
    check_output({tag, "_latency"}, 128'(lat), 128'(exp_lat));
    check_output({tag, "_num_str"}, num_str, exp_str);
    check_output({tag, "_err"}, {127'd0, err}, {127'd0, exp_err});
    check_output({tag, "_busy_in_done"}, {127'd0, busy}, 128'd0);
    @(posedge clk);
    #1;
    check_output({tag, "_done_pulse"}, {127'd0, done}, 128'd0);
  endtask

  initial begin
    int lat;
    passed = 0;
    total  = 0;
    rst    = 1'b1;
    start  = 1'b0;
    value  = '0;
    base   = 5'd10;

    vecs[0]  = '{32'd10,         5'd2,  128'h31303130,         1'b0, 133};
    vecs[1]  = '{32'd127,        5'd16, 128'h3746,             1'b0, 67};
    vecs[2]  = '{32'd63,         5'd8,  128'h3737,             1'b0, 67};
    vecs[3]  = '{32'd0,          5'd10, 128'h30,               1'b0, 34};
    vecs[4]  = '{32'd55,         5'd1,  128'h0,                1'b1, 1};
    vecs[5]  = '{32'd55,         5'd17, 128'h0,                1'b1, 1};
    vecs[6]  = '{32'h0001_0000,  5'd2,  128'h0,                1'b1, 529};
    vecs[7]  = '{32'h0000_FFFF,  5'd2,  {16{8'h31}},           1'b0, 529};
    vecs[8]  = '{32'd255,        5'd10, 128'h323535,           1'b0, 100};
    vecs[9]  = '{32'hFFFF_FFFF,  5'd16, {8{8'h46}},            1'b0, 265};
    vecs[10] = '{32'd42,         5'd0,  128'h0,                1'b1, 1};

    repeat (3) @(posedge clk);
    #1;
    check_output("reset_busy", {127'd0, busy}, 128'd0);
    check_output("reset_done", {127'd0, done}, 128'd0);
    check_output("reset_err", {127'd0, err}, 128'd0);
    check_output("reset_num_str", num_str, 128'd0);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      apply_stimulus(vecs[i].value, vecs[i].base, lat);
      check_result($sformatf("vec%0d", i), vecs[i].str, vecs[i].err, vecs[i].lat, lat);
    end

    // err and cleared num_str persist while idle
    repeat (3) @(posedge clk);
    #1;
    check_output("err_hold", {127'd0, err}, 128'd1);
    check_output("err_hold_num_str", num_str, 128'd0);

    // Reset in the middle of a divide; previous result must be cleared too
    apply_stimulus(32'd255, 5'd10, lat);
    check_result("prep", 128'h323535, 1'b0, 100, lat);
    value = 32'd10;
    base  = 5'd2;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_output("midrst_busy", {127'd0, busy}, 128'd0);
    check_output("midrst_done", {127'd0, done}, 128'd0);
    check_output("midrst_num_str", num_str, 128'd0);
    rst = 1'b0;

    apply_stimulus(32'd5, 5'd3, lat);
    check_result("after_rst", 128'h3132, 1'b0, 67, lat);

    // start held high with new operands while busy must not disturb the conversion
    value = 32'd127;
    base  = 5'd16;
    start = 1'b1;
    @(posedge clk);
    #1;
    value = 32'd5;
    base  = 5'd10;
    lat = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    start = 1'b0;
    while (!done && lat < 2000) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_result("busy_ignore", 128'h3746, 1'b0, 67, lat);

    $display("[TB] %0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
